uart_transmitter: RTL and testbench

- Serializes bytes from the core onto the off-chip UART TX pin as 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- This is the outbound counterpart of the input-conditioning path. Its line output is a clean, glitch-free registered level that a far-end receiver samples asynchronously through its own synchronizer.
- Sits in io_circuits between the core's MMIO/FIFO byte source and the FPGA pin.

---
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with valid/ready byte intake
module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
   localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

   localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CYCLE = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_ZERO   = '0;
   localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_ONE    = CLOCK_COUNTER_WIDTH'(1);

   // A bit must last at least two clocks so the counter has a distinct terminal value.
   if (SYMBOL_EDGE_TIME < 2) begin : g_bad_symbol_time
      $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [7:0]                     shift_q, shift_d;
   logic [2:0]                     bit_idx_q, bit_idx_d;
   logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
   logic                           serial_q, serial_d;
   logic                           ready_q, ready_d;

   logic       bit_done;
   logic [2:0] next_idx;

   assign bit_done = (cycle_cnt_q == LAST_CYCLE);
   assign next_idx = bit_idx_q + 3'd1;

   // Next-state logic: the line level for the upcoming bit is decided here so it is launched from a flop.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      cycle_cnt_d = cycle_cnt_q;
      serial_d    = serial_q;
      ready_d     = ready_q;
      unique case (state_q)
         IDLE: begin
            if (data_in_valid) begin
               shift_d     = data_in;
               state_d     = START;
               serial_d    = 1'b0;
               ready_d     = 1'b0;
               cycle_cnt_d = CNT_ZERO;
            end
         end
         START: begin
            if (bit_done) begin
               cycle_cnt_d = CNT_ZERO;
               state_d     = DATA;
               bit_idx_d   = 3'd0;
               serial_d    = shift_q[0];
            end else begin
               cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (bit_done) begin
               cycle_cnt_d = CNT_ZERO;
               if (bit_idx_q == 3'd7) begin
                  // Index holds at 7 rather than wrapping into the stop bit.
                  state_d  = STOP;
                  serial_d = 1'b1;
               end else begin
                  bit_idx_d = next_idx;
                  serial_d  = shift_q[next_idx];
               end
            end else begin
               cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (bit_done) begin
               cycle_cnt_d = CNT_ZERO;
               state_d     = IDLE;
               ready_d     = 1'b1;
               serial_d    = 1'b1;
            end else begin
               cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            serial_d = 1'b1;
         end
      endcase
   end

   // State and output flops; async reset drives the line to mark immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= 8'h00;
         bit_idx_q   <= 3'd0;
         cycle_cnt_q <= CNT_ZERO;
         serial_q    <= 1'b1;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         cycle_cnt_q <= cycle_cnt_d;
         serial_q    <= serial_d;
         ready_q     <= ready_d;
      end
   end

   assign serial_out    = serial_q;
   assign data_in_ready = ready_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic       serial_out;

   int checks;
   int failures;
   int accepts;

   uart_transmitter #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .serial_out   (serial_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count handshakes as the DUT sees them at each rising edge.
   always @(posedge clk) begin
      if (rst_n && data_in_valid && data_in_ready) accepts <= accepts + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Starting in the cycle after acceptance, check 10 bits of 10 cycles each; leaves the bench at cycle k+101.
   task automatic check_frame(input string tag, input logic [9:0] line);
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 10; c++) begin
            check_bit(tag, serial_out, line[b]);
            check_bit({tag, "_ready_low"}, data_in_ready, 1'b0);
            tick();
         end
      end
      check_bit({tag, "_ready_back"}, data_in_ready, 1'b1);
      check_bit({tag, "_idle_line"}, serial_out, 1'b1);
   endtask

   initial begin
      logic [7:0] rnd_byte;
      logic [7:0] next_byte;
      int         acc_base;

      checks        = 0;
      failures      = 0;
      accepts       = 0;
      rst_n         = 1'b0;
      data_in       = 8'h00;
      data_in_valid = 1'b0;

      // Reset held for three edges, then 50 quiet idle cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_bit("reset_line", serial_out, 1'b1);
         check_bit("reset_ready", data_in_ready, 1'b1);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check_bit("idle_line", serial_out, 1'b1);
         check_bit("idle_ready", data_in_ready, 1'b1);
      end

      // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
      data_in       = 8'hA5;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      check_frame("a5", 10'b1101001010);
      tick();

      // Byte 0x3C captured at acceptance; data_in changes during the frame.
      data_in       = 8'h3C;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      data_in       = 8'hFF;
      check_frame("3c_stable", 10'b1001111000);
      tick();

      // Back-to-back 0x00 then 0xFF with valid held high.
      acc_base      = accepts;
      data_in       = 8'h00;
      data_in_valid = 1'b1;
      tick();
      data_in = 8'hFF;
      check_frame("b2b_00", 10'b1000000000);
      tick();
      data_in_valid = 1'b0;
      check_frame("b2b_ff", 10'b1111111110);
      for (int i = 0; i < 5; i++) tick();
      check_int("b2b_accepts", accepts - acc_base, 2);

      // Mid-frame reset during data bit 3 (cycles k+41..k+50).
      data_in       = 8'h00;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      for (int i = 0; i < 44; i++) tick();
      check_bit("pre_reset_line", serial_out, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("async_reset_line", serial_out, 1'b1);
      check_bit("async_reset_ready", data_in_ready, 1'b1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_bit("post_reset_line", serial_out, 1'b1);
      check_bit("post_reset_ready", data_in_ready, 1'b1);
      data_in       = 8'h81;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      check_frame("81_after_reset", 10'b1100000010);
      tick();

      // Random bytes streamed back-to-back, expected frame built from each byte.
      acc_base      = accepts;
      rnd_byte      = 8'($urandom_range(0, 255));
      data_in       = rnd_byte;
      data_in_valid = 1'b1;
      tick();
      for (int n = 0; n < 16; n++) begin
         next_byte = 8'($urandom_range(0, 255));
         data_in   = next_byte;
         if (n == 15) data_in_valid = 1'b0;
         check_frame("random_frame", {1'b1, rnd_byte, 1'b0});
         rnd_byte = next_byte;
         tick();
      end
      data_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_int("random_accepts", accepts - acc_base, 16);
      check_bit("final_line", serial_out, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
